// File: rtl/comparison_merge_sorter_if.sv
// Packet handshake and data bus between the packet register (master) and the sorter (slave).
interface comparison_merge_sorter_if #(
  parameter int PACKET_WIDTH = 8,
  parameter int INDEX_WIDTH  = 3
);
  logic                                  ready;
  logic [PACKET_WIDTH*8-1:0]             data_in;
  logic [PACKET_WIDTH*INDEX_WIDTH-1:0]   index_in;
  logic [PACKET_WIDTH*8-1:0]             data_out;
  logic [PACKET_WIDTH*INDEX_WIDTH-1:0]   index_out;
  logic                                  sorted;
  logic                                  done;

  modport master (output ready, data_in, index_in,
                  input  data_out, index_out, sorted, done);
  modport slave  (input  ready, data_in, index_in,
                  output data_out, index_out, sorted, done);
endinterface

// File: rtl/comparison_merge_sorter.sv
// Registered bitonic merge sorter: bytes travel with their index tags through K(K+1)/2 layers.
// Optional COMPARISON_MERGE_INDEX_TIEBREAK_EN: key becomes {data, index} for deterministic ties.
module cms_cas #(
  parameter int IW = 3,
  parameter bit UP = 1'b1
) (
  input  logic [7:0]    a_data,
  input  logic [IW-1:0] a_idx,
  input  logic [7:0]    b_data,
  input  logic [IW-1:0] b_idx,
  output logic [7:0]    lo_data,
  output logic [IW-1:0] lo_idx,
  output logic [7:0]    hi_data,
  output logic [IW-1:0] hi_idx
);
`ifdef COMPARISON_MERGE_INDEX_TIEBREAK_EN
  logic [8+IW-1:0] ka, kb;
  assign ka = {a_data, a_idx};
  assign kb = {b_data, b_idx};
`else
  logic [7:0] ka, kb;
  assign ka = a_data;
  assign kb = b_data;
`endif
  // strict compare: equal keys never swap
  logic swap;
  assign swap = UP ? (ka > kb) : (ka < kb);

  assign lo_data = swap ? b_data : a_data;
  assign lo_idx  = swap ? b_idx  : a_idx;
  assign hi_data = swap ? a_data : b_data;
  assign hi_idx  = swap ? a_idx  : b_idx;
endmodule

module comparison_merge_sorter #(
  parameter int PACKET_WIDTH = 8,
  parameter int INDEX_WIDTH  = 3,
  parameter int ASCENDING    = 1
) (
  input logic                       clk,
  input logic                       reset,
  comparison_merge_sorter_if.slave  bus
);
  localparam int N  = PACKET_WIDTH;
  localparam int IW = INDEX_WIDTH;
  localparam int K  = $clog2(N);
  localparam int L  = K * (K + 1) / 2;

  typedef logic [N-1:0][7:0]    dvec_t;
  typedef logic [N-1:0][IW-1:0] ivec_t;

  dvec_t st_d [L];
  ivec_t st_i [L];
  logic [L:1][N-1:0][7:0]    nd;
  logic [L:1][N-1:0][IW-1:0] ni;

  logic [L-1:0] vld_pipe;
  dvec_t        out_d;
  ivec_t        out_i;
  logic         sorted, sorted_q;
  logic         busy, cap;

  assign busy = |vld_pipe;
  assign cap  = bus.ready & ~busy;

  // layer LY reads register LY-1; the last layer feeds the output register directly
  for (genvar p = 1; p <= K; p++) begin : g_ph
    for (genvar s = 0; s < p; s++) begin : g_ly
      localparam int LY = p * (p - 1) / 2 + s + 1;
      localparam int D  = 1 << (p - 1 - s);
      for (genvar i = 0; i < N; i++) begin : g_el
        if ((i & D) == 0) begin : g_cas
          localparam bit UP = (((i >> p) & 1) == 0) == (ASCENDING != 0);
          cms_cas #(.IW(IW), .UP(UP)) u_cas (
            .a_data (st_d[LY-1][i]),
            .a_idx  (st_i[LY-1][i]),
            .b_data (st_d[LY-1][i+D]),
            .b_idx  (st_i[LY-1][i+D]),
            .lo_data(nd[LY][i]),
            .lo_idx (ni[LY][i]),
            .hi_data(nd[LY][i+D]),
            .hi_idx (ni[LY][i+D])
          );
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < L; k++) begin
        st_d[k] <= '0;
        st_i[k] <= '0;
      end
      vld_pipe <= '0;
      out_d    <= '0;
      out_i    <= '0;
      sorted   <= 1'b0;
      sorted_q <= 1'b0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | L'(cap);
      if (cap) begin
        st_d[0] <= bus.data_in;
        st_i[0] <= bus.index_in;
      end
      for (int k = 1; k < L; k++) begin
        st_d[k] <= nd[k];
        st_i[k] <= ni[k];
      end
      if (cap) begin
        sorted <= 1'b0;
      end else if (vld_pipe[L-1]) begin
        out_d  <= nd[L];
        out_i  <= ni[L];
        sorted <= 1'b1;
      end
      sorted_q <= sorted;
    end
  end

  assign bus.data_out  = out_d;
  assign bus.index_out = out_i;
  assign bus.sorted    = sorted;
  assign bus.done      = sorted & ~sorted_q;
endmodule

// File: tb/tb_comparison_merge_sorter.sv
// Bench for comparison_merge_sorter: ascending and descending instances share one stimulus stream.
module tb_comparison_merge_sorter;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int L  = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  comparison_merge_sorter_if #(.PACKET_WIDTH(N), .INDEX_WIDTH(IW)) bus_a ();
  comparison_merge_sorter_if #(.PACKET_WIDTH(N), .INDEX_WIDTH(IW)) bus_d ();

  comparison_merge_sorter #(.PACKET_WIDTH(N), .INDEX_WIDTH(IW), .ASCENDING(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  comparison_merge_sorter #(.PACKET_WIDTH(N), .INDEX_WIDTH(IW), .ASCENDING(0)) dut_d (
    .clk(clk), .reset(reset), .bus(bus_d.slave));

  logic              ready;
  logic [N*8-1:0]    data_in;
  logic [N*IW-1:0]   index_in;
  assign bus_a.ready = ready;  assign bus_a.data_in = data_in;  assign bus_a.index_in = index_in;
  assign bus_d.ready = ready;  assign bus_d.data_in = data_in;  assign bus_d.index_in = index_in;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " data_a"}, bus_a.data_out, 64'h0);
    chk({tag, " index_a"}, 64'(bus_a.index_out), 64'h0);
    chk({tag, " flags"}, 64'({bus_a.sorted, bus_a.done, bus_d.sorted, bus_d.done}), 64'h0);
  endtask

  // Reference: insertion sort on whole elements with the key chosen by the build
  task automatic model_sort(input logic [N*8-1:0] d, input logic [N*IW-1:0] ix, input bit asc,
                            output logic [N*8-1:0] od, output logic [N*IW-1:0] oi);
    logic [7:0]    md [N];
    logic [IW-1:0] mi [N];
    for (int i = 0; i < N; i++) begin
      md[i] = d[8*i +: 8];
      mi[i] = ix[IW*i +: IW];
    end
    for (int i = 1; i < N; i++) begin
      logic [7:0]    cd;
      logic [IW-1:0] ci;
      int j;
      cd = md[i]; ci = mi[i]; j = i;
      while (j > 0) begin
        logic [10:0] kp, kc;
`ifdef COMPARISON_MERGE_INDEX_TIEBREAK_EN
        kp = {md[j-1], mi[j-1]}; kc = {cd, ci};
`else
        kp = {md[j-1], 3'b0};    kc = {cd, 3'b0};
`endif
        if (asc ? (kp > kc) : (kp < kc)) begin
          md[j] = md[j-1]; mi[j] = mi[j-1]; j--;
        end else break;
      end
      md[j] = cd; mi[j] = ci;
    end
    for (int i = 0; i < N; i++) begin
      od[8*i +: 8]   = md[i];
      oi[IW*i +: IW] = mi[i];
    end
  endtask

  function automatic bit pairs_ok(input logic [N*8-1:0] d, input logic [N*IW-1:0] ix,
                                  input logic [N*8-1:0] od, input logic [N*IW-1:0] oi);
    bit used [N];
    for (int i = 0; i < N; i++) used[i] = 1'b0;
    for (int o = 0; o < N; o++) begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < N; i++)
        if (!found && !used[i] && d[8*i +: 8] == od[8*o +: 8] && ix[IW*i +: IW] == oi[IW*o +: IW]) begin
          used[i] = 1'b1; found = 1'b1;
        end
      if (!found) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_result(input string tag, input logic [N*8-1:0] d, input logic [N*IW-1:0] ix);
    logic [N*8-1:0]  ea, ed;
    logic [N*IW-1:0] ia, id;
    model_sort(d, ix, 1'b1, ea, ia);
    model_sort(d, ix, 1'b0, ed, id);
    chk({tag, " asc data"}, bus_a.data_out, ea);
    chk({tag, " desc data"}, bus_d.data_out, ed);
    chk({tag, " asc pairs"}, 64'(pairs_ok(d, ix, bus_a.data_out, bus_a.index_out)), 64'h1);
    chk({tag, " desc pairs"}, 64'(pairs_ok(d, ix, bus_d.data_out, bus_d.index_out)), 64'h1);
`ifdef COMPARISON_MERGE_INDEX_TIEBREAK_EN
    chk({tag, " asc index"}, 64'(bus_a.index_out), 64'(ia));
    chk({tag, " desc index"}, 64'(bus_d.index_out), 64'(id));
`endif
  endtask

  // Capture, check exact latency and the single done pulse, then the result
  task automatic do_sort(input string tag, input logic [N*8-1:0] d, input logic [N*IW-1:0] ix);
    data_in = d; index_in = ix; ready = 1'b1;
    step();
    ready = 1'b0;
    for (int k = 1; k < L; k++) begin
      step();
      chk({tag, " sorted early"}, 64'({bus_a.sorted, bus_d.sorted}), 64'h0);
    end
    step();
    chk({tag, " rise"}, 64'({bus_a.sorted, bus_a.done, bus_d.sorted, bus_d.done}), 64'hF);
    check_result(tag, d, ix);
    step();
    chk({tag, " done fall"}, 64'({bus_a.sorted, bus_a.done, bus_d.sorted, bus_d.done}), 64'hA);
  endtask

  initial begin
    logic [N*8-1:0]  da, db;
    logic [N*IW-1:0] ia;
    int n_done_a, n_done_d, n_sorted;
    ready = 1'b0; data_in = '0; index_in = '0;

    // reset then idle
    repeat (2) step();
    chk_idle("reset");
    reset = 1'b1;
    repeat (3) step();
    chk_idle("idle");
    reset = 1'b0; #1;
    chk_idle("reset mid");
    step(); reset = 1'b1;
    step();
    chk_idle("idle2");

    // directed basic sort, both directions
    do_sort("basic", 64'h33_01_80_7F_00_FF_10_50, 24'o76543210);
    chk("basic asc const", bus_a.data_out, 64'hFF_80_7F_50_33_10_01_00);
    chk("basic asc index", 64'(bus_a.index_out), 64'(24'o25407163));
    chk("basic desc const", bus_d.data_out, 64'h00_01_10_33_50_7F_80_FF);

    // ties
    do_sort("ties", {N{8'h42}}, 24'o76543210);
`ifdef COMPARISON_MERGE_INDEX_TIEBREAK_EN
    chk("ties index unchanged", 64'(bus_a.index_out), 64'(24'o76543210));
`endif

    // busy-ignore: second request two cycles after capture is dropped
    da = 64'h01_02_03_04_F0_E0_D0_C0; ia = 24'o01234567;
    db = 64'h99_99_00_00_AA_AA_55_55;
    data_in = da; index_in = ia; ready = 1'b1;
    step();
    ready = 1'b0;
    step(); step();
    data_in = db; index_in = 24'o76543210; ready = 1'b1;
    step();
    ready = 1'b0;
    step(); step();
    chk("ignore not early", 64'(bus_a.sorted), 64'h0);
    step();
    chk("ignore rise", 64'({bus_a.sorted, bus_a.done}), 64'h3);
    check_result("ignore", da, ia);
    step();
    chk("ignore idle", 64'({bus_a.sorted, bus_a.done}), 64'h2);

    // ready held high: capture on each completion
    da = 64'h10_20_30_40_50_60_70_80; ia = 24'o01234567;
    data_in = da; index_in = ia; ready = 1'b1;
    n_done_a = 0; n_done_d = 0; n_sorted = 0;
    repeat (3 * (L + 1)) begin
      step();
      n_done_a += int'(bus_a.done);
      n_done_d += int'(bus_d.done);
      n_sorted += int'(bus_a.sorted);
    end
    ready = 1'b0;
    chk("b2b done asc", 64'(n_done_a), 64'd3);
    chk("b2b done desc", 64'(n_done_d), 64'd3);
    chk("b2b sorted cycles", 64'(n_sorted), 64'd3);
    check_result("b2b", da, ia);
    step();

    // reset 3 cycles into a sort
    data_in = 64'hDE_AD_BE_EF_01_23_45_67; index_in = 24'o70615243; ready = 1'b1;
    step();
    ready = 1'b0;
    repeat (3) step();
    reset = 1'b0; #1;
    chk_idle("abort");
    step(); reset = 1'b1;
    n_done_a = 0; n_sorted = 0;
    repeat (L + 2) begin
      step();
      n_done_a += int'(bus_a.done) + int'(bus_d.done);
      n_sorted += int'(bus_a.sorted) + int'(bus_d.sorted);
    end
    chk("abort no done", 64'(n_done_a), 64'd0);
    chk("abort no sorted", 64'(n_sorted), 64'd0);
    chk_idle("abort after");
    do_sort("post abort", 64'h05_04_03_02_01_00_07_06, 24'o12345670);

    // randomized
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        da[8*i +: 8] = (r < 3) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      ia = 24'($urandom);
      do_sort($sformatf("rand%0d", r), da, ia);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
